// File: rtl/eu_if.sv
// Exponent unit sample/result bundle.
// master drives samples, slave is the exponent unit.
interface eu_if #(
  parameter int Q         = 26,
  parameter int W         = 32,
  parameter int INT_WIDTH = 5
);
  logic                 valid_in;
  logic [INT_WIDTH-1:0] integer_part;
  logic [Q-1:0]         frac_part;
  logic [W-1:0]         k_coeff;
  logic [W-1:0]         b_intercept;
  logic                 valid_out;
  logic [W-1:0]         exp_result;

  modport master (
    output valid_in,
    output integer_part,
    output frac_part,
    output k_coeff,
    output b_intercept,
    input  valid_out,
    input  exp_result
  );

  modport slave (
    input  valid_in,
    input  integer_part,
    input  frac_part,
    input  k_coeff,
    input  b_intercept,
    output valid_out,
    output exp_result
  );
endinterface

// File: rtl/eu.sv
// GELU exponent unit: 2^x = (k*f + b) << int, 3-stage pipeline.
// Result is signed Q(W-Q-1).Q, saturating on positive overflow.
module eu #(
  parameter int Q         = 26,
  parameter int W         = 32,
  parameter int INT_WIDTH = 5
) (
  input  logic clk,
  input  logic rst,
  eu_if.slave  bus
);

  localparam int PW = W + Q + 1;
  localparam int SW = W + 1 + (2 ** (INT_WIDTH - 1));

  localparam logic signed [SW-1:0] MAXW =
    {{(SW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [SW-1:0] MINW =
    {{(SW-W+1){1'b1}}, {(W-1){1'b0}}};

  logic                        v1_q, v2_q, v3_q;
  logic signed [PW-1:0]        k_x, f_x;
  logic signed [PW-1:0]        prod_d, prod_q;
  logic signed [INT_WIDTH-1:0] int1_q, int2_q;
  logic signed [W-1:0]         b1_q;
  logic signed [W:0]           lin_d, lin_q;
  logic signed [SW-1:0]        wide;
  logic signed [W:0]           sr;
  logic [INT_WIDTH-1:0]        nsh;
  logic [W-1:0]                res_d, res_q;

  // S1: signed slope times the zero-extended fraction
  assign k_x    = {{(PW-W){bus.k_coeff[W-1]}}, bus.k_coeff};
  assign f_x    = {{(PW-Q){1'b0}}, bus.frac_part};
  assign prod_d = k_x * f_x;

  // S2: dropping Q low bits is the floor shift
  assign lin_d = prod_q[PW-1:Q] + {b1_q[W-1], b1_q};

  always_comb begin
    wide  = {{(SW-W-1){lin_q[W]}}, lin_q}
            <<< int2_q[INT_WIDTH-2:0];
    nsh   = -int2_q;
    sr    = lin_q >>> nsh;
    res_d = '0;
    if (!int2_q[INT_WIDTH-1]) begin
      if (wide > MAXW)
        res_d = MAXW[W-1:0];
      else if (wide < MINW)
        res_d = MINW[W-1:0];
      else
        res_d = wide[W-1:0];
    end else if (32'(nsh) < W) begin
      res_d = sr[W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      prod_q <= '0;
      int1_q <= '0;
      b1_q   <= '0;
      lin_q  <= '0;
      int2_q <= '0;
      res_q  <= '0;
    end else begin
      v1_q <= bus.valid_in;
      v2_q <= v1_q;
      v3_q <= v2_q;
      if (bus.valid_in) begin
        prod_q <= prod_d;
        int1_q <= $signed(bus.integer_part);
        b1_q   <= $signed(bus.b_intercept);
      end
      if (v1_q) begin
        lin_q  <= lin_d;
        int2_q <= int1_q;
      end
      if (v2_q)
        res_q <= res_d;
    end
  end

  assign bus.valid_out  = v3_q;
  assign bus.exp_result = res_q;

endmodule

// File: tb/tb_eu.sv
// Randomized bench for eu against an arithmetic 2^x reference.
// Checks latency, hold, saturation, accuracy and mid-flight reset.
module tb_eu;

  localparam real SCALE = 67108864.0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  eu_if #(.Q(26), .W(32), .INT_WIDTH(5)) bus ();

  eu #(.Q(26), .W(32), .INT_WIDTH(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  int          lut_k [8];
  int          lut_b [8];
  logic [31:0] last  = '0;

  int          qdue   [$];
  logic [31:0] qval   [$];
  bit          qacc   [$];
  real         qideal [$];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] model(int ip, longint fr,
                                        int k, int b);
    longint lin, v;
    lin = ((longint'(k) * fr) >>> 26) + longint'(b);
    if (ip >= 0) begin
      v = lin * (longint'(1) << ip);
      if (v > 64'sh7FFFFFFF) v = 64'sh7FFFFFFF;
    end else begin
      v = lin >>> (-ip);
    end
    return v[31:0];
  endfunction

  task automatic check_out();
    real got_r, err;
    chk("xprop", 64'($isunknown({bus.valid_out, bus.exp_result})), 0);
    if (qdue.size() > 0 && qdue[0] == cyc) begin
      chk("vout1", 64'(bus.valid_out), 1);
      chk("res", 64'(bus.exp_result), 64'(qval[0]));
      if (qacc[0]) begin
        got_r = real'($signed(bus.exp_result)) / SCALE;
        err = got_r - qideal[0];
        if (err < 0.0) err = -err;
        err = err / qideal[0];
        chk("acc", 64'(err <= 0.001), 1);
      end
      last = qval[0];
      void'(qdue.pop_front());
      void'(qval.pop_front());
      void'(qacc.pop_front());
      void'(qideal.pop_front());
    end else begin
      chk("vout0", 64'(bus.valid_out), 0);
      chk("hold", 64'(bus.exp_result), 64'(last));
    end
  endtask

  task automatic tick(bit vin, int ip, longint fr, int k, int b,
                      logic [31:0] ev, bit acc, real ideal);
    @(posedge clk);
    cyc++;
    #1;
    if (vin) begin
      bus.valid_in     = 1'b1;
      bus.integer_part = ip[4:0];
      bus.frac_part    = fr[25:0];
      bus.k_coeff      = k;
      bus.b_intercept  = b;
      qdue.push_back(cyc + 3);
      qval.push_back(ev);
      qacc.push_back(acc);
      qideal.push_back(ideal);
    end else begin
      bus.valid_in     = 1'b0;
      bus.integer_part = 5'($urandom);
      bus.frac_part    = 26'($urandom);
      bus.k_coeff      = $urandom;
      bus.b_intercept  = $urandom;
    end
    @(negedge clk);
    check_out();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++)
      tick(1'b0, 0, 0, 0, 0, '0, 1'b0, 1.0);
  endtask

  task automatic send_raw(int ip, longint fr, bit use_c,
                          logic [31:0] cv, bit acc);
    int          s;
    logic [31:0] ev;
    real         ideal;
    s = int'(fr >> 23);
    ev = use_c ? cv : model(ip, fr, lut_k[s], lut_b[s]);
    ideal = 2.0 ** (real'(ip) + real'(fr) / SCALE);
    tick(1'b1, ip, fr, lut_k[s], lut_b[s], ev, acc, ideal);
  endtask

  task automatic send(int ip, real f, bit use_c,
                      logic [31:0] cv, bit acc);
    send_raw(ip, longint'($rtoi(f * SCALE)), use_c, cv, acc);
  endtask

  initial begin
    real x, y0, y1, kr, br;
    int  ip;
    bus.valid_in     = 1'b0;
    bus.integer_part = '0;
    bus.frac_part    = '0;
    bus.k_coeff      = '0;
    bus.b_intercept  = '0;

    for (int s = 0; s < 8; s++) begin
      y0 = 2.0 ** (real'(s) / 8.0);
      y1 = 2.0 ** (real'(s + 1) / 8.0);
      kr = (y1 - y0) * 8.0;
      br = y0 - kr * real'(s) / 8.0;
      lut_k[s] = $rtoi(kr * SCALE + 0.5);
      lut_b[s] = $rtoi(br * SCALE + 0.5);
    end

    #3;
    chk("rst_vout", 64'(bus.valid_out), 0);
    chk("rst_res", 64'(bus.exp_result), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(10);

    send(0, 0.0, 1'b1, 32'h0400_0000, 1'b1);
    idle(4);
    send(1, 0.0, 1'b1, 32'h0800_0000, 1'b1);
    idle(4);
    send(-1, 0.0, 1'b1, 32'h0200_0000, 1'b1);
    idle(4);
    send(0, 0.125, 1'b0, '0, 1'b1);
    send(2, 0.5, 1'b0, '0, 1'b1);
    send(-1, 0.5, 1'b0, '0, 1'b1);
    idle(5);

    for (int i = 0; i < 80; i++) begin
      x = -4.9375 + 0.125 * real'(i);
      ip = $rtoi($floor(x));
      send(ip, x - real'(ip), 1'b0, '0, 1'b1);
    end
    idle(4);

    send(5, 0.5, 1'b1, 32'h7FFF_FFFF, 1'b0);
    send(15, 0.9, 1'b1, 32'h7FFF_FFFF, 1'b0);
    send(-16, 0.0, 1'b0, '0, 1'b0);
    send(-16, 0.99, 1'b0, '0, 1'b0);
    idle(4);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        ip = int'($urandom_range(0, 31)) - 16;
        send_raw(ip, longint'($urandom_range(0, 32'h03FF_FFFF)),
                 1'b0, '0, (ip >= -5 && ip <= 4));
      end else begin
        idle(1);
      end
    end
    idle(5);
    chk("drain", 64'(qdue.size()), 0);

    send(0, 0.3, 1'b0, '0, 1'b1);
    send(1, 0.6, 1'b0, '0, 1'b1);
    send(-2, 0.8, 1'b0, '0, 1'b1);
    send(3, 0.1, 1'b0, '0, 1'b1);
    idle(1);
    rst = 1'b1;
    #1;
    chk("mrst_vout", 64'(bus.valid_out), 0);
    chk("mrst_res", 64'(bus.exp_result), 0);
    qdue.delete();
    qval.delete();
    qacc.delete();
    qideal.delete();
    last = '0;
    idle(2);
    rst = 1'b0;
    idle(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "watchdog");
  end

endmodule
